// File: rtl/rv_muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit beside the execute-stage ALU.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready/in_op/in_rs1/
// in_rs2/in_tag request; out_valid/out_ready/out_result/out_tag response; busy.
module rv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic [XLEN-1:0]  quo, rem, dvs;
    logic             neg_q, neg_r;

    logic accept;
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    // Multiply: extend each operand to 2*XLEN per its signedness; the low
    // 2*XLEN bits of that product are the exact full-precision result.
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]   mul_res;
    always_comb begin
        ma      = {{XLEN{a_q[XLEN-1] & (op_q != 2'd3)}}, a_q};
        mb      = {{XLEN{b_q[XLEN-1] & ~op_q[1]}}, b_q};
        prod    = ma * mb;
        mul_res = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix;
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs};
        q_fix  = neg_q ? -quo : quo;
        r_fix  = neg_r ? -rem : rem;
    end

    // Request-side decode: operand magnitudes and the no-iteration cases.
    logic            s1, s2, div0, ovf, spec_hit;
    logic [XLEN-1:0] abs1, abs2, spec_res;
    always_comb begin
        s1       = ~in_op[0] & in_rs1[XLEN-1];
        s2       = ~in_op[0] & in_rs2[XLEN-1];
        abs1     = s1 ? -in_rs1 : in_rs1;
        abs2     = s2 ? -in_rs2 : in_rs2;
        div0     = (in_rs2 == '0);
        ovf      = ~in_op[0] & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                   & (in_rs2 == '1);
        spec_hit = div0 | ovf;
        spec_res = '0;
        if (div0)
            spec_res = in_op[1] ? in_rs1 : '1;
        else if (ovf)
            spec_res = in_op[1] ? '0 : in_rs1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            op_q  <= in_op[1:0];
            tag_q <= in_tag;
            cnt   <= '0;
            busy  <= 1'b1;
            if (!in_op[2]) begin
                state     <= MUL;
                a_q       <= in_rs1;
                b_q       <= in_rs2;
                out_valid <= 1'b0;
            end else if (spec_hit) begin
                state      <= DONE;
                out_valid  <= 1'b1;
                out_result <= spec_res;
                out_tag    <= in_tag;
            end else begin
                state     <= DIV;
                quo       <= abs1;
                rem       <= '0;
                dvs       <= abs2;
                neg_q     <= s1 ^ s2;
                neg_r     <= s1;
                out_valid <= 1'b0;
            end
        end else begin
            unique case (state)
                MUL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MUL_STAGES - 1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= mul_res;
                        out_tag    <= tag_q;
                    end
                end
                DIV: begin
                    if (cnt == CW'(XLEN)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= op_q[1] ? r_fix : q_fix;
                        out_tag    <= tag_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: randomised and directed M-extension ops
// checked against a plain-arithmetic reference model.
module tb_rv_muldiv_unit;
    localparam int XLEN = 32;
    localparam int MS   = 2;
    localparam int TW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = '0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic [TW-1:0]   out_tag;
    logic            busy;

    rv_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_rdy = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] op,
                                      input logic [31:0] a, b);
        if (op < 3'd4) return 0;
        if (b == 0) return 1;
        return !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] op,
                                           input logic [31:0] a, b);
        int          sa, sb;
        longint      p;
        logic [63:0] u;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin
                p = longint'(sa) * longint'({32'd0, b});
                return p[63:32];
            end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (is_special(op, a, b)) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (is_special(op, a, b)) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] a, b);
        if (op < 3'd4) return MS;
        if (is_special(op, a, b)) return 0;
        return XLEN + 1;
    endfunction

    // Call at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, b,
                         input logic [4:0] tag, output int acc);
        exp_t e;
        bit   ok;
        ok       = 0;
        acc      = -1;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc   = cyc;
        e.res = ref_op(op, a, b);
        e.tag = tag;
        e.lat = ref_lat(op, a, b);
        e.acc = acc;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #3;
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: pop and compare on every output handshake.
    bit   vis = 0;
    int   first = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (!rst_n || flush) begin
            vis = 0;
        end else if (out_valid) begin
            if (!vis) begin
                vis   = 1;
                first = cyc;
            end
            if (out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("result", out_result, mon_e.res);
                    check("tag", out_tag, mon_e.tag);
                    check("latency", first - mon_e.acc, mon_e.lat);
                end
                vis = 0;
            end
        end
    end

    always @(negedge clk)
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, rel;
        bit bad;
        logic [2:0] rop;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", out_result, 0);
        check("rst_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, a0);
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, a1);
        check("mul_throughput", a1 - a0, MS + 1);
        issue(1, 32'h80000000, 32'h80000000, 1, a0);
        issue(2, 32'hFFFFFFFF, 32'h00000002, 2, a0);
        issue(4, 32'hFFFFFFF9, 32'd2, 3, a0);
        issue(6, 32'hFFFFFFF9, 32'd2, 4, a0);
        issue(5, 32'd100, 32'd7, 5, a0);
        issue(7, 32'd100, 32'd7, 6, a0);
        issue(5, 32'd55, 32'd0, 9, a0);
        issue(6, 32'h1234, 32'd0, 10, a0);
        issue(4, 32'h80000000, 32'hFFFFFFFF, 11, a0);
        issue(6, 32'h80000000, 32'hFFFFFFFF, 12, a0);
        drain();

        out_ready = 1'b0;
        issue(0, 32'h00012345, 32'h00000100, 5, a0);
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid_timeout", bad, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_result", out_result, 32'h01234500);
            check("bp_tag", out_tag, 5);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        rel = cyc;
        issue(0, 32'd3, 32'd5, 13, a1);
        check("bp_release_accept", a1, rel + 1);
        drain();

        issue(4, 32'd1000, 32'd7, 3, a0);
        repeat (10) @(negedge clk);
        #1;
        check("div_busy", busy, 1);
        check("div_no_valid", out_valid, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_rs1   = 32'd2;
        in_rs2   = 32'd2;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        check("flush_busy", busy, 0);
        check("flush_valid", out_valid, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (out_valid) bad = 1;
        end
        check("flush_never_valid", bad, 0);
        @(negedge clk);
        issue(5, 32'd9, 32'd3, 14, a0);
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, pick(), pick(), 5'($urandom_range(0, 31)), a0);
        end
        drain();
        rand_rdy  = 0;
        out_ready = 1'b1;
        @(negedge clk);

        issue(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 17, a0);
        drain();
        issue(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 21, a0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        q.delete();
        check("mrst_valid", out_valid, 0);
        check("mrst_result", out_result, 0);
        check("mrst_tag", out_tag, 0);
        check("mrst_busy", busy, 0);
        check("mrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 32'd6, 32'd7, 22, a0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
